// File: rtl/memory_access_pkg.sv
// Shared definitions for the load/store stage: RV32I width codes, FSM states,
// byte-enable patterns and the legality/alignment helpers.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic op_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes the access size for every legal code
    function automatic logic op_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return ~offset[0];
            2'b10:   return offset == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory port: request with address/data/byte enables, completed by ready.
interface memory_access_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_be;
    logic                  dmem_ready;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/memory_access_load_align.sv
// Extracts the addressed byte/half from a memory word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[7:0];
        case (offset)
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            2'd3:    byte_val = rdata[31:24];
            default: byte_val = rdata[7:0];
        endcase
        half_val = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_val[7]}}, byte_val};
            F3_LH:   load_data = {{16{half_val[15]}}, half_val};
            F3_LBU:  load_data = {24'd0, byte_val};
            F3_LHU:  load_data = {16'd0, half_val};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Load/store pipeline stage: issues one data-memory transaction at a time,
// stalls upstream while it is outstanding and registers the writeback bundle.
module memory_access
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ALU_out,
    input  logic [DATA_WIDTH-1:0] r_out2,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_write,
    output logic                  stall,
    memory_access_if.master       dmem,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_fault,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data
);

    mem_state_t state, next_state;

    logic                  is_mem;
    logic                  op_ok;
    logic                  accept;
    logic                  fault;
    logic                  pass;
    logic                  complete;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] load_data;

    logic [DATA_WIDTH-1:0] op_addr;
    logic [1:0]            op_offset;
    logic [2:0]            op_funct3;
    logic [4:0]            op_rd;
    logic                  op_reg_write;
    logic                  op_we;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [3:0]            op_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        is_mem     = ex_mem_read | ex_mem_write;
        op_ok      = op_legal(ex_mem_write, ex_funct3) && op_aligned(ex_funct3, ALU_out[1:0]);
        accept     = 1'b0;
        fault      = 1'b0;
        pass       = 1'b0;
        complete   = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_mem)     pass   = 1'b1;
                    else if (op_ok)  accept = 1'b1;
                    else             fault  = 1'b1;
                end
                if (accept) next_state = BUSY;
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        stall = (state == BUSY);
    end

    // Store lanes are replicated so the byte enables alone pick the target bytes
    always_comb begin
        st_wdata = r_out2;
        st_be    = BE_WORD;
        if (ex_mem_write) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    st_wdata = {4{r_out2[7:0]}};
                    st_be    = BE_BYTE << ALU_out[1:0];
                end
                2'b01: begin
                    st_wdata = {2{r_out2[15:0]}};
                    st_be    = BE_HALF << ALU_out[1:0];
                end
                default: begin
                    st_wdata = r_out2;
                    st_be    = BE_WORD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_addr      <= '0;
            op_offset    <= '0;
            op_funct3    <= '0;
            op_rd        <= '0;
            op_reg_write <= 1'b0;
            op_we        <= 1'b0;
            op_wdata     <= '0;
            op_be        <= '0;
        end else if (accept) begin
            op_addr      <= {ALU_out[DATA_WIDTH-1:2], 2'b00};
            op_offset    <= ALU_out[1:0];
            op_funct3    <= ex_funct3;
            op_rd        <= ex_rd;
            op_reg_write <= ex_reg_write;
            op_we        <= ex_mem_write;
            op_wdata     <= st_wdata;
            op_be        <= st_be;
        end
    end

    always_comb begin
        dmem.dmem_req   = (state == BUSY);
        dmem.dmem_we    = (state == BUSY) && op_we;
        dmem.dmem_addr  = op_addr;
        dmem.dmem_wdata = op_wdata;
        dmem.dmem_be    = op_be;
    end

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .rdata    (dmem.dmem_rdata),
        .offset   (op_offset),
        .funct3   (op_funct3),
        .load_data(load_data)
    );

    // Qualifiers drop with wb_valid so a stale write-enable never lingers; rd/data hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
            if (complete) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= op_reg_write && !op_we;
                wb_rd        <= op_rd;
                wb_data      <= op_we ? '0 : load_data;
            end else if (fault) begin
                wb_valid <= 1'b1;
                wb_fault <= 1'b1;
                wb_rd    <= ex_rd;
                wb_data  <= '0;
            end else if (pass) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= ex_reg_write;
                wb_rd        <= ex_rd;
                wb_data      <= ALU_out;
            end
        end
    end

endmodule
